// File: rtl/serializador_resultado.sv
// serializador_resultado: converts a signed 32-bit result into ASCII
// decimal text ('-', digits MSB first, optional terminator) for a UART TX.
// Ports:
//   clk, reset          clock, async active-high reset
//   resultado[31:0]     signed value, valid while dato_listo is high
//   dato_listo          1-cycle capture pulse
//   tx_done             1-cycle pulse: current byte shifted out
//   tx_data[7:0]        byte for the UART TX
//   tx_start            1-cycle pulse: UART TX loads tx_data
//   busy                high from capture until fin_envio, inclusive
//   fin_envio           1-cycle pulse after the last byte completes
//   perdido             1-cycle pulse: dato_listo dropped while busy
module serializador_resultado #(
  parameter logic [7:0] TERMINADOR      = 8'h0A,
  parameter bit         USAR_TERMINADOR = 1'b1,
  parameter logic [7:0] CARACTER_SIGNO  = 8'h2D
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] resultado,
  input  logic        dato_listo,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        busy,
  output logic        fin_envio,
  output logic        perdido
);

  typedef enum logic [2:0] {
    IDLE, SIGNO, CONV, ENVIO, ESPERA, TERM, FIN
  } estado_t;

  // Kind of the byte currently in flight; selects where ESPERA returns.
  typedef enum logic [1:0] {
    B_SIGNO, B_DIGITO, B_TERM
  } byte_t;

  estado_t     estado_q;
  byte_t       ultimo_q;
  logic [32:0] mag_q;
  logic [3:0]  k_q;
  logic [3:0]  dig_q;
  logic        emitido_q;
  logic [7:0]  tx_data_q;
  logic        tx_start_q;
  logic        busy_q;
  logic        fin_q;
  logic        perdido_q;

  logic [32:0] ext_d;
  logic [32:0] mag_d;
  logic [32:0] pot_d;
  logic        mayor_d;

  // 33 bits so that -(-2^31) = 2^31 is representable.
  always_comb begin
    ext_d = {resultado[31], resultado};
    mag_d = resultado[31] ? (~ext_d + 33'd1) : ext_d;
  end

  always_comb begin
    pot_d = 33'd1;
    case (k_q)
      4'd9:    pot_d = 33'd1_000_000_000;
      4'd8:    pot_d = 33'd100_000_000;
      4'd7:    pot_d = 33'd10_000_000;
      4'd6:    pot_d = 33'd1_000_000;
      4'd5:    pot_d = 33'd100_000;
      4'd4:    pot_d = 33'd10_000;
      4'd3:    pot_d = 33'd1_000;
      4'd2:    pot_d = 33'd100;
      4'd1:    pot_d = 33'd10;
      default: pot_d = 33'd1;
    endcase
    mayor_d = (mag_q >= pot_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q   <= IDLE;
      ultimo_q   <= B_SIGNO;
      mag_q      <= '0;
      k_q        <= '0;
      dig_q      <= '0;
      emitido_q  <= 1'b0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
      perdido_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      fin_q      <= 1'b0;
      perdido_q  <= dato_listo && (estado_q != IDLE);
      unique case (estado_q)
        IDLE: begin
          if (dato_listo) begin
            mag_q     <= mag_d;
            k_q       <= 4'd9;
            dig_q     <= 4'd0;
            emitido_q <= 1'b0;
            busy_q    <= 1'b1;
            estado_q  <= resultado[31] ? SIGNO : CONV;
          end else begin
            busy_q <= 1'b0;
          end
        end
        SIGNO: begin
          tx_data_q  <= CARACTER_SIGNO;
          tx_start_q <= 1'b1;
          ultimo_q   <= B_SIGNO;
          estado_q   <= ESPERA;
        end
        CONV: begin
          if (mayor_d) begin
            mag_q <= mag_q - pot_d;
            dig_q <= dig_q + 4'd1;
          end else if (dig_q != 4'd0 || emitido_q || k_q == 4'd0) begin
            emitido_q <= 1'b1;
            estado_q  <= ENVIO;
          end else begin
            // leading zero: skip without sending
            k_q <= k_q - 4'd1;
          end
        end
        ENVIO: begin
          tx_data_q  <= {4'h3, dig_q};
          tx_start_q <= 1'b1;
          ultimo_q   <= B_DIGITO;
          estado_q   <= ESPERA;
        end
        ESPERA: begin
          if (tx_done) begin
            if (ultimo_q == B_SIGNO) begin
              estado_q <= CONV;
            end else if (ultimo_q == B_TERM) begin
              estado_q <= FIN;
            end else if (k_q != 4'd0) begin
              k_q      <= k_q - 4'd1;
              dig_q    <= 4'd0;
              estado_q <= CONV;
            end else begin
              estado_q <= USAR_TERMINADOR ? TERM : FIN;
            end
          end
        end
        TERM: begin
          tx_data_q  <= TERMINADOR;
          tx_start_q <= 1'b1;
          ultimo_q   <= B_TERM;
          estado_q   <= ESPERA;
        end
        FIN: begin
          fin_q    <= 1'b1;
          estado_q <= IDLE;
        end
        default: estado_q <= IDLE;
      endcase
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_start  = tx_start_q;
  assign busy      = busy_q;
  assign fin_envio = fin_q;
  assign perdido   = perdido_q;

endmodule

// File: tb/tb_serializador_resultado.sv
// Testbench for serializador_resultado: two instances (with and without
// terminator) share inputs; a UART stub answers tx_start with tx_done.
module tb_serializador_resultado;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] resultado;
  logic        dato_listo;
  logic        tx_done;
  logic        tx_done_auto = 1'b0;
  logic        tx_done_man;
  logic [7:0]  tx_data_a, tx_data_b;
  logic        tx_start_a, tx_start_b;
  logic        busy_a, busy_b;
  logic        fin_a, fin_b;
  logic        perd_a, perd_b;

  assign tx_done = tx_done_auto | tx_done_man;

  always #5 clk = ~clk;

  serializador_resultado dut_a (
    .clk(clk), .reset(reset), .resultado(resultado),
    .dato_listo(dato_listo), .tx_done(tx_done),
    .tx_data(tx_data_a), .tx_start(tx_start_a), .busy(busy_a),
    .fin_envio(fin_a), .perdido(perd_a)
  );

  serializador_resultado #(.USAR_TERMINADOR(1'b0)) dut_b (
    .clk(clk), .reset(reset), .resultado(resultado),
    .dato_listo(dato_listo), .tx_done(tx_done),
    .tx_data(tx_data_b), .tx_start(tx_start_b), .busy(busy_b),
    .fin_envio(fin_b), .perdido(perd_b)
  );

  // UART stub: tx_done pulse 'retardo' cycles after tx_start of dut_a
  int retardo = 5;
  int cnt = 0;
  always @(posedge clk) begin
    #2;
    if (reset) begin
      cnt = 0;
      tx_done_auto = 1'b0;
    end else begin
      tx_done_auto = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) tx_done_auto = 1'b1;
      end
      if (tx_start_a) cnt = retardo;
    end
  end

  // Collectors
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  int cyc = 0, last_done = 0, gap_b = 0;
  int n_fin_a = 0, n_fin_b = 0, n_perd_a = 0, n_perd_b = 0;
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (tx_start_a) qa.push_back(tx_data_a);
      if (tx_start_b) qb.push_back(tx_data_b);
      if (tx_done) last_done = cyc;
      if (fin_a) n_fin_a++;
      if (fin_b) begin
        n_fin_b++;
        gap_b = cyc - last_done;
      end
      if (perd_a) n_perd_a++;
      if (perd_b) n_perd_b++;
    end
  end

  int n_chk = 0, n_err = 0;
  int ba, bb, fa, fb;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cmp_stream(input string nm, input int base,
                            input bit lado_a, input string s,
                            input bit term);
    logic [7:0] ex[$];
    logic [7:0] got[$];
    bit ok;
    string gs, es;
    for (int i = 0; i < s.len(); i++) ex.push_back(s[i]);
    if (term) ex.push_back(8'h0A);
    if (lado_a) for (int i = base; i < qa.size(); i++) got.push_back(qa[i]);
    else for (int i = base; i < qb.size(); i++) got.push_back(qb[i]);
    ok = (got.size() == ex.size());
    if (ok) foreach (ex[i]) if (got[i] !== ex[i]) ok = 1'b0;
    gs = "";
    es = "";
    foreach (got[i]) gs = {gs, $sformatf("%02h ", got[i])};
    foreach (ex[i]) es = {es, $sformatf("%02h ", ex[i])};
    n_chk++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s (%s): got [%s] expected [%s]", nm, s, gs, es);
    end
  endtask

  task automatic iniciar(input logic [31:0] v);
    ba = qa.size();
    bb = qb.size();
    fa = n_fin_a;
    fb = n_fin_b;
    @(negedge clk);
    resultado = v;
    dato_listo = 1'b1;
    @(negedge clk);
    dato_listo = 1'b0;
  endtask

  task automatic terminar(input string s);
    int t;
    t = 0;
    while (n_fin_a == fa && t < 4000) begin
      @(negedge clk);
      t++;
    end
    chk({"timeout ", s}, 64'(t >= 4000), 64'd0);
    repeat (3) @(negedge clk);
    cmp_stream("stream_a", ba, 1'b1, s, 1'b1);
    cmp_stream("stream_b", bb, 1'b0, s, 1'b0);
    chk({"fin_a ", s}, 64'(n_fin_a - fa), 64'd1);
    chk({"fin_b ", s}, 64'(n_fin_b - fb), 64'd1);
    chk({"busy_end ", s}, {busy_a, busy_b}, 64'd0);
  endtask

  task automatic enviar(input logic [31:0] v, input string s);
    iniciar(v);
    terminar(s);
  endtask

  // Reference: the decimal text of the signed value
  function automatic string modelo(input logic [31:0] v);
    return $sformatf("%0d", $signed(v));
  endfunction

  typedef struct {
    logic [31:0] v;
    string       s;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [31:0] v, input string s);
    vec_t e;
    e.v = v;
    e.s = s;
    tbl.push_back(e);
  endtask

  initial begin
    int sz, p0, p1, t;
    logic [31:0] v;
    reset = 1'b1;
    dato_listo = 1'b0;
    resultado = '0;
    tx_done_man = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_a", {tx_data_a, tx_start_a, busy_a, fin_a, perd_a}, 64'd0);
    chk("reset_b", {tx_data_b, tx_start_b, busy_b, fin_b, perd_b}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    add(32'd1234, "1234");
    add(32'd0, "0");
    add(32'd1000000000, "1000000000");
    add(-32'sd7, "-7");
    add(32'h80000000, "-2147483648");
    add(32'd2147483647, "2147483647");
    add(32'd5, "5");
    foreach (tbl[i]) enviar(tbl[i].v, tbl[i].s);

    // '-' tx_start on the 2nd edge after dato_listo
    iniciar(-32'sd7);
    chk("lat_pre", tx_start_a, 1'b0);
    chk("busy_capture", busy_a, 1'b1);
    @(negedge clk);
    chk("lat_sign", {tx_start_a, tx_data_a}, {1'b1, 8'h2D});
    terminar("-7");

    // No terminator: fin_envio one cycle after the edge consuming the
    // last tx_done; the collector sees tx_done on the negedge before
    // that edge, so the observed distance is 2 negedges.
    enviar(32'd42, "42");
    chk("fin_gap_b", 64'(gap_b), 64'd2);

    // Dropped dato_listo and stray tx_done in CONV
    p0 = n_perd_a;
    p1 = n_perd_b;
    iniciar(32'd1234);
    t = 0;
    while (qa.size() < ba + 2 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_byte2", 64'(t >= 1000), 64'd0);
    resultado = 32'd99;
    dato_listo = 1'b1;
    @(negedge clk);
    dato_listo = 1'b0;
    t = 0;
    while (!tx_done_auto && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done2", 64'(t >= 100), 64'd0);
    @(negedge clk);
    tx_done_man = 1'b1;
    @(negedge clk);
    tx_done_man = 1'b0;
    terminar("1234");
    chk("perdido_a", 64'(n_perd_a - p0), 64'd1);
    chk("perdido_b", 64'(n_perd_b - p1), 64'd1);
    sz = qa.size();
    repeat (40) @(negedge clk);
    chk("no_stream_99", 64'(qa.size() - sz), 64'd0);

    // Reset mid-stream
    iniciar(32'd1234);
    t = 0;
    while (qa.size() < ba + 2 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("wait_byte2_rst", 64'(t >= 1000), 64'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rst_mid_a", {tx_data_a, tx_start_a, busy_a, fin_a, perd_a}, 64'd0);
    chk("rst_mid_b", {tx_data_b, tx_start_b, busy_b, fin_b, perd_b}, 64'd0);
    sz = qa.size();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tx_done_man = 1'b1;
    @(negedge clk);
    tx_done_man = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_tx_after_rst", 64'(qa.size() - sz), 64'd0);
    chk("idle_after_rst", {busy_a, busy_b}, 64'd0);
    enviar(32'd5, "5");

    // Randomized values and UART delays
    for (int i = 0; i < 25; i++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom;
        1: v = $urandom_range(0, 20);
        2: v = -$urandom_range(0, 100000);
        default: v = $urandom_range(0, 999999);
      endcase
      retardo = $urandom_range(1, 8);
      enviar(v, modelo(v));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
